clkdiv_multi: RTL and testbench

- Multi-channel programmable clock-enable/clock divider. Each channel divides the system clock by a runtime-set integer and has a runtime-set high time.
- Each channel also emits a one-cycle period-start tick.
- New settings arrive through a valid/ready config port and take effect only at a period boundary, so no output glitches.
- Sits between the system clock domain and slow peripherals (UART baud, SPI SCLK, LED/PWM timing). Reset defaults give 100 MHz -> 1 MHz at 50% duty.

---
 rtl/clkdiv_multi.sv | 124 ++++++++++++
 tb/tb_clkdiv_multi.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with per-channel period-start tick.
// New divisor/high-time settings are shadowed and only take effect at a period boundary.
module clkdiv_multi #(
  parameter int NCH      = 2,
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 100,
  parameter int DEF_HIGH = 50,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_err,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  logic [NCH-1:0] pending;
  logic           ch_ok;
  logic           ready_sel;
  logic           cfg_xfer;
  logic           cfg_bad;
  logic           cfg_err_reg;

  // Out-of-range channels always accept so a bad request cannot stall the port.
  always_comb begin
    ch_ok     = 1'b0;
    ready_sel = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        ch_ok     = 1'b1;
        ready_sel = !pending[i];
      end
    end
  end

  assign cfg_ready = ready_sel;
  assign cfg_xfer  = cfg_valid && ready_sel;
  assign cfg_bad   = !ch_ok || (cfg_div < CNT_W'(2));
  assign cfg_err   = cfg_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_xfer && cfg_bad;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] high_reg, high_next;
    logic [CNT_W-1:0] div_sh_reg, high_sh_reg;
    logic             pend_reg, pend_next;
    logic             run_reg;
    logic             clk_reg, clk_next;
    logic             tick_reg, tick_next;
    logic             load;
    logic             wrap;
    logic             boundary;
    logic             apply;

    // A period boundary is a wrap, the first enabled cycle, or any disabled cycle.
    always_comb begin
      load      = cfg_xfer && !cfg_bad && (cfg_ch == CH_W'(gi));
      wrap      = (cnt_reg == (div_reg - CNT_W'(1)));
      boundary  = !en[gi] || !run_reg || wrap;
      apply     = pend_reg && boundary;
      div_next  = apply ? div_sh_reg  : div_reg;
      high_next = apply ? high_sh_reg : high_reg;
      if (!en[gi] || !run_reg || wrap) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
      clk_next  = en[gi] && (cnt_next < high_next);
      tick_next = en[gi] && (cnt_next == '0);
      if (load) begin
        pend_next = 1'b1;
      end else if (apply) begin
        pend_next = 1'b0;
      end else begin
        pend_next = pend_reg;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg     <= '0;
        div_reg     <= CNT_W'(DEF_DIV);
        high_reg    <= CNT_W'(DEF_HIGH);
        div_sh_reg  <= CNT_W'(DEF_DIV);
        high_sh_reg <= CNT_W'(DEF_HIGH);
        pend_reg    <= 1'b0;
        run_reg     <= 1'b0;
        clk_reg     <= 1'b0;
        tick_reg    <= 1'b0;
      end else begin
        cnt_reg  <= cnt_next;
        div_reg  <= div_next;
        high_reg <= high_next;
        pend_reg <= pend_next;
        run_reg  <= en[gi];
        clk_reg  <= clk_next;
        tick_reg <= tick_next;
        if (load) begin
          div_sh_reg  <= cfg_div;
          high_sh_reg <= cfg_high;
        end
      end
    end

    assign pending[gi] = pend_reg;
    assign clk_out[gi] = clk_reg;
    assign tick[gi]    = tick_reg;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed + randomized bench for clkdiv_multi; a period-start-time reference model
// predicts clk_out, tick, cfg_ready and cfg_err every cycle.
module tb_clkdiv_multi;
  localparam int NCH   = 3;
  localparam int CNT_W = 16;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  clkdiv_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(100), .DEF_HIGH(50)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_err(cfg_err),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each channel remembers the edge index at which its current period began.
  int k = 0;
  int m_start[NCH], m_div[NCH], m_high[NCH], m_pdiv[NCH], m_phigh[NCH];
  bit m_pend[NCH], m_run[NCH];
  logic [NCH-1:0] e_clk, e_tick;
  logic e_err;

  bit count_on = 0;
  int hi0 = 0, tk0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    if (int'(cfg_ch) >= NCH) return 1'b1;
    return !m_pend[int'(cfg_ch)];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_start[c] = 0; m_div[c] = 100; m_high[c] = 50;
      m_pdiv[c] = 100; m_phigh[c] = 50; m_pend[c] = 0; m_run[c] = 0;
    end
    e_clk = '0; e_tick = '0; e_err = 1'b0;
  endtask

  task automatic model_apply(input int c);
    if (m_pend[c]) begin
      m_div[c] = m_pdiv[c]; m_high[c] = m_phigh[c]; m_pend[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit acc, bad;
    int c, ph;
    k++;
    c   = int'(cfg_ch);
    acc = cfg_valid && model_ready();
    bad = (c >= NCH) || (int'(cfg_div) < 2);
    e_err = acc && bad;
    for (int ch = 0; ch < NCH; ch++) begin
      if (!en[ch]) begin
        model_apply(ch);
        m_run[ch] = 0; e_clk[ch] = 1'b0; e_tick[ch] = 1'b0;
      end else begin
        if (!m_run[ch] || ((k - 1) - m_start[ch]) == m_div[ch] - 1) begin
          model_apply(ch);
          m_start[ch] = k;
        end
        m_run[ch] = 1;
        ph = k - m_start[ch];
        e_clk[ch]  = (ph < m_high[ch]);
        e_tick[ch] = (ph == 0);
      end
    end
    if (acc && !bad) begin
      m_pend[c] = 1; m_pdiv[c] = int'(cfg_div); m_phigh[c] = int'(cfg_high);
    end
  endtask

  // One clock: check cfg_ready before the edge, then outputs just after it.
  task automatic step();
    #1;
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, model_ready()});
    @(posedge clk);
    model_edge();
    #1;
    chk("clk_out", {29'd0, clk_out}, {29'd0, e_clk});
    chk("tick", {29'd0, tick}, {29'd0, e_tick});
    chk("cfg_err", {31'd0, cfg_err}, {31'd0, e_err});
    if (count_on) begin
      hi0 += int'(clk_out[0]);
      tk0 += int'(tick[0]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int ch, input int ph);
    int n = 0;
    while (!(m_run[ch] && (k - m_start[ch]) == ph) && n < 2000) begin
      step(); n++;
    end
    chk("run_to_reached", {31'd0, n < 2000}, 32'd1);
  endtask

  task automatic wait_pend_clear(input int ch);
    int n = 0;
    while (m_pend[ch] && n < 2000) begin
      step(); n++;
    end
    chk("pend_cleared", {31'd0, m_pend[ch]}, 32'd0);
  endtask

  task automatic send_cfg(input int ch, input int d, input int h);
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(d); cfg_high = CNT_W'(h);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("async_rst_clk_out", {29'd0, clk_out}, 32'd0);
    chk("async_rst_tick", {29'd0, tick}, 32'd0);
    chk("async_rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(posedge clk);
    k++;
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_clk_out", {29'd0, clk_out}, 32'd0);
    chk("reset_tick", {29'd0, tick}, 32'd0);
    chk("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
    rst = 1'b0;

    // Defaults on ch0: period 100, 50 high, one tick per period.
    en = 3'b001;
    count_on = 1;
    run(300);
    count_on = 0;
    chk("default_high_cycles", hi0, 32'd150);
    chk("default_ticks", tk0, 32'd3);

    // Mid-period reconfiguration of ch0.
    run_to(0, 40);
    send_cfg(0, 10, 3);
    cfg_ch = 2'd0;
    wait_pend_clear(0);
    run(40);

    // Boundary settings on ch1.
    en = 3'b011;
    send_cfg(1, 10, 5);
    wait_pend_clear(1);
    run(25);
    send_cfg(1, 5, 0);
    wait_pend_clear(1);
    run(15);
    send_cfg(1, 5, 7);
    wait_pend_clear(1);
    run(15);
    send_cfg(1, 2, 1);
    wait_pend_clear(1);
    run(10);
    send_cfg(1, 1, 1);
    chk("div1_no_pending", {31'd0, m_pend[1]}, 32'd0);
    run(10);
    send_cfg(1, 0, 3);
    run(6);

    // Config presented on the exact wrap cycle of a default period.
    do_reset();
    en = 3'b001;
    run_to(0, 99);
    send_cfg(0, 20, 4);
    cfg_ch = 2'd0;
    run(130);

    // Dropping en with a pending config, then re-enabling.
    run_to(0, 5);
    send_cfg(0, 8, 6);
    run(3);
    en = 3'b000;
    step();
    chk("en_drop_clk_out0", {31'd0, clk_out[0]}, 32'd0);
    chk("en_drop_applied", {31'd0, m_pend[0]}, 32'd0);
    run(4);
    en = 3'b001;
    step();
    chk("reenable_tick0", {31'd0, tick[0]}, 32'd1);
    chk("reenable_clk0", {31'd0, clk_out[0]}, 32'd1);
    run(20);

    // Out-of-range channel.
    send_cfg(3, 10, 5);
    step();
    run(3);

    // Randomized operation.
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) en = NCH'($urandom_range(0, 7));
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      cfg_div   = CNT_W'($urandom_range(0, 12));
      cfg_high  = CNT_W'($urandom_range(0, 14));
      step();
    end
    cfg_valid = 1'b0;

    // Reset while a config is pending.
    en = 3'b001;
    run(3);
    wait_pend_clear(0);
    run_to(0, 1);
    send_cfg(0, 6, 2);
    chk("pending_before_rst", {31'd0, m_pend[0]}, 32'd1);
    do_reset();
    cfg_ch = 2'd0;
    #1;
    chk("ready_after_rst", {31'd0, cfg_ready}, 32'd1);
    hi0 = 0; tk0 = 0; count_on = 1;
    run(200);
    count_on = 0;
    chk("post_rst_high_cycles", hi0, 32'd100);
    chk("post_rst_ticks", tk0, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
